// File: rtl/fifo_rd_stream.sv
// Converts a FIFO read port (1 or 2 cycle read latency) into a registered valid/ready stream via a small skid buffer.
// Optional beat counter enabled by defining FIFO_RD_STREAM_BEAT_CNT_EN; otherwise beat_cnt is tied to 0.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_oce,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level,
    output logic [31:0]           beat_cnt
);

    localparam logic [1:0] DEPTH = 2'(RD_LATENCY + 1);

    logic [DATA_WIDTH-1:0] mem [0:3];
    logic [1:0]            wr_ptr, rd_ptr, level;
    logic [RD_LATENCY-1:0] rd_sr;
    logic                  active;
    logic                  push, pop;
    logic [2:0]            inflight, occ;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == DEPTH - 2'd1) ? 2'd0 : p + 2'd1;
    endfunction

    assign push      = rd_sr[RD_LATENCY-1];
    assign pop       = m_valid && m_ready;
    assign m_valid   = (level != 2'd0);
    assign m_data    = mem[rd_ptr];
    assign buf_level = level;

    // rd_sr already includes the word landing this cycle, so no separate push term
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + {2'b0, rd_sr[i]};
        occ = {1'b0, level} + inflight - {2'b0, pop};
    end

    assign fifo_rd_en = active && !fifo_rd_empty && (occ < {1'b0, DEPTH});

    generate
        if (RD_LATENCY == 2) begin : g_oce_reg
            assign fifo_rd_oce = rd_sr[0];
        end else begin : g_oce_const
            assign fifo_rd_oce = rd_rst_n;
        end
    endgenerate

    // active holds off reads until the first edge after reset release
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            active <= 1'b0;
            rd_sr  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < 4; i++)
                mem[i] <= '0;
        end else begin
            active <= 1'b1;
            rd_sr  <= (rd_sr << 1) | RD_LATENCY'(fifo_rd_en);
            if (push) begin
                mem[wr_ptr] <= fifo_rd_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                level <= level + 2'd1;
            else if (!push && pop)
                level <= level - 2'd1;
        end
    end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [31:0] beat_cnt_r;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n)
            beat_cnt_r <= '0;
        else if (pop)
            beat_cnt_r <= beat_cnt_r + 32'd1;
    end

    assign beat_cnt = beat_cnt_r;
`else
    assign beat_cnt = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge rd_clk) begin
        if (rd_rst_n)
            assert (!(push && !pop && level == DEPTH))
                else $error("fifo_rd_stream: push into full skid buffer");
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench driving a RD_LATENCY=1 and a RD_LATENCY=2 instance in lockstep against a queue-based FIFO/stream model.
module tb_fifo_rd_stream;
    localparam int DW = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                m_ready = 1'b0;
    logic [1:0]          rd_en, oce, empty, m_valid;
    logic [1:0][DW-1:0]  rd_data, m_data;
    logic [1:0][1:0]     level;
    logic [1:0][31:0]    beat_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_lane
        fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(g + 1)) u_dut (
            .rd_clk(clk), .rd_rst_n(rst_n),
            .fifo_rd_en(rd_en[g]), .fifo_rd_oce(oce[g]),
            .fifo_rd_data(rd_data[g]), .fifo_rd_empty(empty[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready), .m_data(m_data[g]),
            .buf_level(level[g]), .beat_cnt(beat_cnt[g])
        );
    end

    int unsigned fq [2][$];
    int unsigned eq [2][$];
    logic [DW-1:0] s1;
    logic [1:0]    take, prev_en;
    logic [31:0]   bc_exp [2];
    logic [DW-1:0] stall_data [2];
    bit            stalled [2], arm [2];
    int            cyc, checks, errs;
    int            fall_cyc [2], first_beat [2], last_beat [2], nbeats [2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic put(input int unsigned w);
        for (int i = 0; i < 2; i++) begin
            if (eq[i].size() == 0 && rst_n) begin
                arm[i]      = 1'b1;
                fall_cyc[i] = cyc;
            end
            fq[i].push_back(w);
            eq[i].push_back(w);
            empty[i] = 1'b0;
        end
    endtask

    // sample on negedge, then advance the FIFO model just after the posedge
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) chk("rd_en_while_empty", empty[i], 0);
            take[i] = rd_en[i] && !empty[i];
            if (!rst_n) begin
                stalled[i] = 1'b0;
            end else begin
                if (i == 1 && (oce[1] || prev_en[1])) chk("oce_track", oce[1], prev_en[1]);
                if (i == 0) chk("oce_const", oce[0], 1);
                chk("level_bound", level[i] <= 2'(i + 2), 1);
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
                chk("beat_cnt", beat_cnt[i], bc_exp[i]);
`else
                chk("beat_cnt_zero", beat_cnt[i], 0);
`endif
                if (m_valid[i] && arm[i]) begin
                    arm[i] = 1'b0;
                    chk("first_latency", cyc - fall_cyc[i], i + 2);
                end
                if (stalled[i]) chk("stall_hold", m_data[i], stall_data[i]);
                if (m_valid[i] && m_ready) begin
                    if (eq[i].size() == 0) chk("spurious_beat", 1, 0);
                    else chk("beat_data", m_data[i], eq[i].pop_front());
                    nbeats[i]++;
                    bc_exp[i] += 32'd1;
                    if (first_beat[i] < 0) first_beat[i] = cyc;
                    last_beat[i] = cyc;
                end
                stalled[i]    = m_valid[i] && !m_ready;
                stall_data[i] = m_data[i];
            end
            prev_en[i] = rd_en[i];
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [DW-1:0] w;
            w = (take[i] && fq[i].size() != 0) ? fq[i].pop_front() : $urandom();
            if (i == 0) rd_data[0] = w;
            else begin
                rd_data[1] = s1;
                s1 = w;
            end
            empty[i] = (fq[i].size() == 0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int nb [2];
        int waited;
        empty = 2'b00;
        rd_data = '0;
        s1 = '0;
        prev_en = '0;
        for (int i = 0; i < 2; i++) begin
            bc_exp[i] = '0; first_beat[i] = -1; nbeats[i] = 0; arm[i] = 1'b0; stalled[i] = 1'b0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", m_valid[i], 0);
            chk("rst_level", level[i], 0);
            chk("rst_data", m_data[i], 0);
            chk("rst_rd_en", rd_en[i], 0);
            chk("rst_oce", oce[i], 0);
            chk("rst_beat_cnt", beat_cnt[i], 0);
        end
        empty = 2'b11;
        run(3);
        rst_n = 1'b1;
        run(3);

        // burst: sustained one beat per cycle
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) first_beat[i] = -1;
        for (int k = 0; k < 8; k++) put($urandom());
        run(20);
        for (int i = 0; i < 2; i++) begin
            chk("burst_span", last_beat[i] - first_beat[i], 7);
            chk("burst_drained", eq[i].size(), 0);
        end

        // sink stalled: buffer saturates and head holds
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) put(32'h1000 + k);
        run(12);
        for (int i = 0; i < 2; i++) begin
            chk("stall_level", level[i], i + 2);
            chk("stall_rd_en", rd_en[i], 0);
            chk("stall_head", m_data[i], 32'h1000);
        end
        m_ready = 1'b1;
        run(20);
        for (int i = 0; i < 2; i++) chk("stall_drained", eq[i].size(), 0);

        // ready toggling, FIFO empties after 5 words
        for (int i = 0; i < 2; i++) nb[i] = nbeats[i];
        for (int k = 0; k < 5; k++) put(32'h2000 + k);
        for (int k = 0; k < 30; k++) begin
            m_ready = cyc[0];
            tick();
        end
        for (int i = 0; i < 2; i++) chk("toggle_beats", nbeats[i] - nb[i], 5);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            m_ready = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) put($urandom());
            tick();
        end
        m_ready = 1'b1;
        run(40);
        for (int i = 0; i < 2; i++) chk("random_drained", eq[i].size(), 0);

        // reset mid-operation with two buffered and one read in flight
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) put(32'h3000 + k);
        waited = 0;
        while (level[1] != 2'd2 && waited < 20) begin
            tick();
            waited++;
        end
        chk("wait_level2", level[1], 2);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_valid", m_valid[i], 0);
            chk("midrst_level", level[i], 0);
            chk("midrst_beat_cnt", beat_cnt[i], 0);
            chk("midrst_rd_en", rd_en[i], 0);
            eq[i] = fq[i];
            bc_exp[i] = '0;
            arm[i] = 1'b0;
        end
        run(2);
        rst_n = 1'b1;
        m_ready = 1'b1;
        run(30);
        for (int i = 0; i < 2; i++) chk("midrst_drained", eq[i].size(), 0);

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        force gen_lane[0].u_dut.beat_cnt_r = 32'hFFFF_FFFE;
        force gen_lane[1].u_dut.beat_cnt_r = 32'hFFFF_FFFE;
        #1;
        release gen_lane[0].u_dut.beat_cnt_r;
        release gen_lane[1].u_dut.beat_cnt_r;
        for (int i = 0; i < 2; i++) bc_exp[i] = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) put($urandom());
        run(10);
        for (int i = 0; i < 2; i++) chk("beat_cnt_wrap", beat_cnt[i], 32'h1);
`else
        for (int i = 0; i < 2; i++) chk("beat_cnt_off", beat_cnt[i], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
